serdes_rx_link_ctrl: RTL
========================

Name: serdes_rx_link_ctrl

Overview:
Receive-side link controller for the 8-bit SerDes lane. It takes the raw MSB-first serial bit stream, finds and locks the word boundary using a repeated sync word, and then emits aligned parallel data words with a one-cycle valid strobe. Sync words are treated as idle fill and are discarded. It sits between the serial line input and the parallel consumer, and it takes over the word-boundary and lock sequencing that the free-running de-serializer does not provide.

Parameters:
WIDTH, 8, parallel word width in bits
LOG_WIDTH, 3, width of the bit counter; equals log2(WIDTH)
SYNC_WORD, 8'hBC, alignment/idle pattern; payload data must never equal this value
LOCK_COUNT, 4, number of consecutive aligned sync words needed to declare lock; must be at least 2
SYNC_GAP, 16, number of consecutive non-sync words after which lock is declared lost

Ports:
clock_in  input  1  single bit-rate clock; everything is sampled on its rising edge
reset_n  input  1  synchronous, active-low reset
din  input  1  serial data, MSB of each word first
enable  input  1  when low, forces the controller back to hunting
dout  output  WIDTH  last aligned data word
dout_valid  output  1  one-cycle pulse when dout is updated with a new data word
locked  output  1  high while in LOCKED
state  output  2  current state: 0 HUNT, 1 VERIFY, 2 LOCKED (3 is unused)
lock_loss_cnt  output  8  saturating count of LOCKED->HUNT transitions

Behaviour:
- Interface: one clock, clock_in. Reset reset_n is synchronous and active-low.
- Reset (reset_n=0 at an edge). Reset has priority over everything else. Values after reset:
  - shreg=0, bit_cnt=0, good_cnt=0, gap_cnt=0
  - state=HUNT, dout=0, dout_valid=0, locked=0, lock_loss_cnt=0
- Shift register: on every edge, shreg <= {shreg[WIDTH-2:0], din}. The shift continues regardless of state or enable.
- Define nxt = {shreg[WIDTH-2:0], din}. All word comparisons use nxt, so a word is judged on the same edge that samples its last bit.
- enable=0 at an edge (with reset_n=1):
  - state<=HUNT, bit_cnt/good_cnt/gap_cnt<=0, dout_valid<=0, locked<=0
  - lock_loss_cnt and dout hold
  - a LOCKED->HUNT move caused by enable does not increment lock_loss_cnt
- dout_valid defaults to 0 on every edge. It goes high only where stated below.
- Word boundary: bit_cnt increments each edge in VERIFY/LOCKED and wraps from WIDTH-1 to 0. The edge with bit_cnt==WIDTH-1 is the "word edge".
- HUNT:
  - nxt is compared with SYNC_WORD on every edge.
  - On a match: state<=VERIFY, bit_cnt<=0, good_cnt<=1.
- VERIFY (evaluated only at word edges):
  - nxt==SYNC_WORD: good_cnt<=good_cnt+1. If good_cnt+1==LOCK_COUNT, then state<=LOCKED, locked<=1, gap_cnt<=0.
  - nxt!=SYNC_WORD: state<=HUNT, good_cnt<=0. No sync match is evaluated on this edge; hunting resumes on the next edge.
  - dout_valid stays 0 throughout VERIFY.
- LOCKED (evaluated only at word edges):
  - nxt==SYNC_WORD: treated as idle. gap_cnt<=0, no output.
  - nxt!=SYNC_WORD and gap_cnt+1<SYNC_GAP: dout<=nxt, dout_valid<=1, gap_cnt<=gap_cnt+1.
  - nxt!=SYNC_WORD and gap_cnt+1==SYNC_GAP: this word is not output. state<=HUNT, locked<=0, gap_cnt<=0, and lock_loss_cnt increments, saturating at 255.
- Latency: dout and dout_valid are visible in the cycle after the edge that sampled the word's last bit, which is one clock after that bit is presented.
- Maximum output rate: one dout_valid pulse every WIDTH cycles. Pulses are always spaced by a multiple of WIDTH cycles.
- Reset applied mid-word or mid-lock aborts immediately at that edge. No partial word is ever output.
- Expected size: roughly 150-250 lines of RTL. The counters are sized LOG_WIDTH bits (bit_cnt), ceil(log2(LOCK_COUNT+1)) bits (good_cnt) and ceil(log2(SYNC_GAP+1)) bits (gap_cnt).

Test Plan:
1. Reset for 2 cycles, then send 4x 0xBC MSB-first with enable=1.
   - state=VERIFY after bit 8, LOCKED after bit 32 (locked=1).
   - dout_valid never pulses.
2. From lock, send 0x55, 0xBC, 0xA3.
   - Exactly two dout_valid pulses, 16 cycles apart, with dout=0x55 then 0xA3.
   - 0xBC is dropped; lock_loss_cnt=0.
3. Prefix bits 1,0,1, then 4x 0xBC, then 0x3C.
   - Lock after 35 bits.
   - dout=0x3C with one valid pulse, which shows the boundary is aligned to the sync word and not to reset.
4. Send 2x 0xBC, then 0x00.
   - HUNT->VERIFY->HUNT on the 24th bit edge.
   - locked stays 0, lock_loss_cnt=0, no dout_valid.
5. From lock, send 16x 0x11.
   - 15 dout_valid pulses with dout=0x11.
   - On the 16th word edge: state=HUNT, locked=0, lock_loss_cnt=1.
6. From lock, pull enable=0 for one cycle: state=HUNT, locked=0, lock_loss_cnt unchanged. Re-lock, then assert reset_n=0 mid-word: all outputs return to their reset values on that edge, including lock_loss_cnt=0.

Source files
------------

// File: rtl/serdes_rx_link_ctrl.sv
// -----------------------------------------------------------------------------
// serdes_rx_link_ctrl
//
// Receive-side link controller for an MSB-first serial lane. Hunts for the
// sync word on every bit, verifies it on a word grid until LOCK_COUNT
// consecutive sync words are seen, then emits aligned data words. Sync words
// in the locked stream are idle fill and are dropped. SYNC_GAP consecutive
// non-sync words while locked drop the link back to hunting.
//
// Ports:
//   clock_in      in   bit-rate clock, rising edge
//   reset_n       in   synchronous active-low reset
//   din           in   serial data, MSB of each word first
//   enable        in   low forces the controller back to HUNT
//   dout          out  last aligned data word (WIDTH bits)
//   dout_valid    out  one-cycle strobe when dout carries a new word
//   locked        out  high while in LOCKED
//   state         out  current state: 0 HUNT, 1 VERIFY, 2 LOCKED
//   lock_loss_cnt out  saturating count of LOCKED->HUNT gap losses
//
// Output handshake: dout_valid is a pure strobe with no ready/back-pressure.
// The consumer must take dout in the cycle dout_valid is high; dout itself
// holds its value until the next strobe.
// -----------------------------------------------------------------------------
module serdes_rx_link_ctrl #(
  parameter int                 WIDTH      = 8,
  parameter int                 LOG_WIDTH  = 3,
  parameter logic [WIDTH-1:0]   SYNC_WORD  = 8'hBC,
  parameter int                 LOCK_COUNT = 4,
  parameter int                 SYNC_GAP   = 16
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             din,
  input  logic             enable,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             locked,
  output logic [1:0]       state,
  output logic [7:0]       lock_loss_cnt
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int GAP_W  = $clog2(SYNC_GAP + 1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [LOG_WIDTH-1:0] LAST_BIT   = LOG_WIDTH'(WIDTH - 1);
  localparam logic [GOOD_W-1:0]    LOCK_CNT_C = GOOD_W'(LOCK_COUNT);
  localparam logic [GAP_W-1:0]     GAP_C      = GAP_W'(SYNC_GAP);

  logic [WIDTH-1:0]     r_shreg;
  logic [LOG_WIDTH-1:0] r_bit_cnt;
  logic [GOOD_W-1:0]    r_good_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_dout;
  logic                 r_dout_valid;
  logic                 r_locked;
  logic [7:0]           r_lock_loss_cnt;

  // Word as it will look after this edge's shift; judging on this lets a word
  // be acted on at the same edge that samples its last bit.
  logic [WIDTH-1:0]     w_nxt;
  logic                 w_is_sync;
  logic                 w_word_edge;
  logic [LOG_WIDTH-1:0] w_bit_next;
  logic [GOOD_W-1:0]    w_good_inc;
  logic [GAP_W-1:0]     w_gap_inc;

  assign w_nxt       = {r_shreg[WIDTH-2:0], din};
  assign w_is_sync   = (w_nxt == SYNC_WORD);
  assign w_word_edge = (r_bit_cnt == LAST_BIT);
  assign w_bit_next  = w_word_edge ? '0 : r_bit_cnt + LOG_WIDTH'(1);
  assign w_good_inc  = r_good_cnt + GOOD_W'(1);
  assign w_gap_inc   = r_gap_cnt + GAP_W'(1);

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_shreg         <= '0;
      r_bit_cnt       <= '0;
      r_good_cnt      <= '0;
      r_gap_cnt       <= '0;
      r_state         <= ST_HUNT;
      r_dout          <= '0;
      r_dout_valid    <= 1'b0;
      r_locked        <= 1'b0;
      r_lock_loss_cnt <= '0;
    end else begin
      // The deserializer shift is free-running, independent of state/enable.
      r_shreg      <= w_nxt;
      r_dout_valid <= 1'b0;

      if (!enable) begin
        // Administrative drop: not counted as a lock loss, dout is kept.
        r_state    <= ST_HUNT;
        r_bit_cnt  <= '0;
        r_good_cnt <= '0;
        r_gap_cnt  <= '0;
        r_locked   <= 1'b0;
      end else begin
        case (r_state)
          ST_HUNT: begin
            // Bit-by-bit search; a match fixes the word boundary here.
            if (w_is_sync) begin
              r_state    <= ST_VERIFY;
              r_bit_cnt  <= '0;
              r_good_cnt <= GOOD_W'(1);
            end
          end

          ST_VERIFY: begin
            r_bit_cnt <= w_bit_next;
            if (w_word_edge) begin
              if (w_is_sync) begin
                r_good_cnt <= w_good_inc;
                if (w_good_inc == LOCK_CNT_C) begin
                  r_state   <= ST_LOCKED;
                  r_locked  <= 1'b1;
                  r_gap_cnt <= '0;
                end
              end else begin
                // Bad word on the grid: boundary was false, start over.
                r_state    <= ST_HUNT;
                r_good_cnt <= '0;
              end
            end
          end

          ST_LOCKED: begin
            r_bit_cnt <= w_bit_next;
            if (w_word_edge) begin
              if (w_is_sync) begin
                r_gap_cnt <= '0;
              end else if (w_gap_inc >= GAP_C) begin
                // Too long without idle fill: assume alignment is gone and
                // discard this word rather than emit possibly misaligned data.
                r_state    <= ST_HUNT;
                r_locked   <= 1'b0;
                r_gap_cnt  <= '0;
                r_good_cnt <= '0;
                if (r_lock_loss_cnt != 8'hFF) begin
                  r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
                end
              end else begin
                r_dout       <= w_nxt;
                r_dout_valid <= 1'b1;
                r_gap_cnt    <= w_gap_inc;
              end
            end
          end

          default: begin
            r_state    <= ST_HUNT;
            r_bit_cnt  <= '0;
            r_good_cnt <= '0;
            r_gap_cnt  <= '0;
            r_locked   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout          = r_dout;
  assign dout_valid    = r_dout_valid;
  assign locked        = r_locked;
  assign state         = r_state;
  assign lock_loss_cnt = r_lock_loss_cnt;

endmodule
